imm_builder: RTL and testbench
==============================

IMM_BUILDER -- requirements
Module: imm_builder

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 11, the width of one operand chunk.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the width of the extended result; legal range is DATA_WIDTH > OPERAND_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: discards any pending prefix chunks.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand chunk is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the chunk is accepted this cycle when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data, input, OPERAND_WIDTH bits: the operand chunk.
REQ-009 SHALL have port in_prefix, input, 1 bit: 1 = prefix chunk (more chunks follow); 0 = final chunk.
REQ-010 SHALL have port in_signed, input, 1 bit, sampled with the final chunk: 1 = sign-extend, 0 = zero-extend.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits: the extended immediate.
REQ-014 SHALL have port out_overflow, output, 1 bit: the accumulated field exceeded DATA_WIDTH and its upper bits were discarded.

Function
REQ-015 SHALL implement FSM states IDLE (nothing pending), ACCUM (at least one prefix chunk held) and OUT (result held, out_valid=1).
REQ-016 SHALL drive in_ready = (!out_valid || out_ready) && !flush, combinationally.
REQ-017 SHALL, on acceptance, update acc <= (acc << OPERAND_WIDTH) | in_data truncated to DATA_WIDTH, and increment the chunk count cnt, saturating at CHUNK_MAX = ceil(DATA_WIDTH/OPERAND_WIDTH)+1.
REQ-018 SHALL, on an accepted prefix chunk, go to ACCUM and leave out_valid unchanged unless out_ready drains it.
REQ-019 SHALL, on an accepted final chunk, register the result one cycle later: out_valid=1; state OUT; acc and cnt cleared.
REQ-020 SHALL compute field width fw = min(cnt_total*OPERAND_WIDTH, DATA_WIDTH), where cnt_total includes the final chunk.
REQ-021 SHALL set out_data[fw-1:0] = acc field; bits above fw SHALL all equal acc[fw-1] when signed, else 0.
REQ-022 SHALL set out_overflow = (cnt_total*OPERAND_WIDTH > DATA_WIDTH), registered together with out_data.
REQ-023 SHALL clear out_valid in the cycle after out_valid && out_ready unless a new final chunk is accepted in that same cycle, in which case the new result SHALL load with no bubble.
REQ-024 SHALL hold out_data and out_overflow stable while out_valid && !out_ready.
REQ-025 SHALL, on flush, clear acc and cnt and return from ACCUM to IDLE; a held result is unaffected; a chunk offered the same cycle is not accepted.
REQ-026 SHALL, with a single final chunk and no prefix, produce the plain sign/zero extension of in_data to DATA_WIDTH.

Reset
REQ-027 SHALL, on rst high, immediately set state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0 and out_overflow=0, independent of clk.
REQ-028 SHALL drop a partially accumulated immediate when reset is asserted mid-operation; no result for it is ever produced.

Structure
REQ-029 SHALL take the state enum type (IDLE/ACCUM/OUT) and the CHUNK_MAX computation from a shared package imm_pkg.
REQ-030 SHALL instantiate a sub-module imm_ext_field (combinational: acc, fw, signed in; DATA_WIDTH-bit extended value out) to perform the variable-width extension.

Verification
REQ-031 SHALL cover single-chunk extension: final chunk 0x400 signed -> out_data=0xFFFFFC00, overflow=0; the same chunk unsigned -> 0x00000400.
REQ-032 SHALL cover two-chunk assembly: prefix 0x001 then final 0x7FF signed -> 0x00000FFF; prefix 0x400 then final 0x000 signed -> 0xFFE00000.
REQ-033 SHALL cover overflow: prefix 0x7FF, prefix 0x7FF, final 0x7FF signed -> out_data=0xFFFFFFFF, out_overflow=1.
REQ-034 SHALL cover backpressure: with out_ready=0 for 3 cycles, out_data is held stable and in_ready=0; then out_ready=1 with a final chunk 0x005 presented -> the next cycle gives 0x00000005 back-to-back with no bubble.
REQ-035 SHALL cover flush and reset: prefix 0x123, then flush, then final 0x001 unsigned -> 0x00000001; prefix 0x123, then rst pulse -> out_valid=0 and the next final 0x002 unsigned -> 0x00000002.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and sizing helpers for the immediate builder.
// Holds the FSM state encoding and the chunk-count saturation limit.
package imm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } imm_state_e;

    // One more than the number of chunks needed to fill the result, so overflow stays visible.
    function automatic int chunk_max(input int data_width, input int operand_width);
        return (data_width + operand_width - 1) / operand_width + 1;
    endfunction

endpackage

// File: rtl/imm_ext_field.sv
// Extends the low fw bits of an accumulated field to the full result width,
// replicating bit fw-1 when signed, zero-filling otherwise.
module imm_ext_field
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FW_W       = $clog2(DATA_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0] acc_i,
    input  logic [FW_W-1:0]       fw_i,
    input  logic                  signed_i,
    output logic [DATA_WIDTH-1:0] ext_o
);

    logic [FW_W-1:0]       fw_m1_s;
    logic                  sign_bit_s;
    logic [DATA_WIDTH-1:0] mask_s;

    // Select the field's top bit and build the field mask.
    always_comb begin
        fw_m1_s    = fw_i - FW_W'(1);
        sign_bit_s = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            sign_bit_s = (FW_W'(i) == fw_m1_s) ? acc_i[i] : sign_bit_s;
        end
        mask_s = ~({DATA_WIDTH{1'b1}} << fw_i);
        ext_o  = (acc_i & mask_s) |
                 ((signed_i && sign_bit_s) ? ~mask_s : {DATA_WIDTH{1'b0}});
    end

endmodule

// File: rtl/imm_builder.sv
// Assembles an immediate from a stream of prefix chunks plus one final chunk
// and registers its sign/zero-extended value with an overflow flag.
module imm_builder
    import imm_pkg::*;
#(
    parameter int OPERAND_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_data,
    input  logic                     in_prefix,
    input  logic                     in_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_overflow
);

    localparam int CHUNK_MAX = chunk_max(DATA_WIDTH, OPERAND_WIDTH);
    localparam int CNT_W     = $clog2(CHUNK_MAX + 1);
    localparam int FW_W      = $clog2(DATA_WIDTH + 1);

    imm_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_ovf_q, out_ovf_d;

    logic                  accept_s;
    logic [DATA_WIDTH-1:0] acc_shift_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic [31:0]           bits_total_s;
    logic                  ovf_s;
    logic [FW_W-1:0]       fw_s;
    logic [DATA_WIDTH-1:0] ext_s;

    assign out_valid    = (state_q == ST_OUT);
    assign in_ready     = (!out_valid || out_ready) && !flush;
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;
    assign accept_s     = in_valid && in_ready;

    // Datapath for the chunk being accepted; the count includes this chunk.
    always_comb begin
        acc_shift_s  = (acc_q << OPERAND_WIDTH) | DATA_WIDTH'(in_data);
        cnt_inc_s    = (cnt_q == CNT_W'(CHUNK_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        bits_total_s = 32'(cnt_inc_s) * 32'(OPERAND_WIDTH);
        ovf_s        = (bits_total_s > 32'(DATA_WIDTH));
        fw_s         = ovf_s ? FW_W'(DATA_WIDTH) : FW_W'(bits_total_s);
    end

    imm_ext_field #(
        .DATA_WIDTH (DATA_WIDTH),
        .FW_W       (FW_W)
    ) u_ext (
        .acc_i    (acc_shift_s),
        .fw_i     (fw_s),
        .signed_i (in_signed),
        .ext_o    (ext_s)
    );

    // Next-state and register loads.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (accept_s) begin
            if (in_prefix) begin
                state_d = ST_ACCUM;
                acc_d   = acc_shift_s;
                cnt_d   = cnt_inc_s;
            end else begin
                state_d    = ST_OUT;
                acc_d      = {DATA_WIDTH{1'b0}};
                cnt_d      = {CNT_W{1'b0}};
                out_data_d = ext_s;
                out_ovf_d  = ovf_s;
            end
        end else begin
            if (flush) begin
                acc_d = {DATA_WIDTH{1'b0}};
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                ST_ACCUM: state_d = flush ? ST_IDLE : ST_ACCUM;
                ST_OUT:   state_d = out_ready ? ST_IDLE : ST_OUT;
                ST_IDLE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= {DATA_WIDTH{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            out_data_q <= {DATA_WIDTH{1'b0}};
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_imm_builder.sv
// Directed bench for imm_builder with hand-computed expected results.
module tb_imm_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_data;
    logic        in_prefix;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_overflow;

    int total_checks = 0;
    int failed_checks = 0;

    imm_builder #(.OPERAND_WIDTH(11), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_prefix    (in_prefix),
        .in_signed    (in_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected)
        else begin
            failed_checks++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] d, input logic pfx, input logic sgn);
        in_valid  = 1'b1;
        in_data   = d;
        in_prefix = pfx;
        in_signed = sgn;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_data, input logic exp_ovf);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp_data));
        check({tag, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 11'h000;
        in_prefix = 1'b0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ovf", 64'(out_overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Single-chunk extension, second one back-to-back
        send(11'h400, 1'b0, 1'b1);
        check_result("single_signed", 32'hFFFF_FC00, 1'b0);
        send(11'h400, 1'b0, 1'b0);
        check_result("single_unsigned", 32'h0000_0400, 1'b0);
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Two-chunk assembly
        send(11'h001, 1'b1, 1'b1);
        check("accum_no_valid", 64'(out_valid), 64'd0);
        send(11'h7FF, 1'b0, 1'b1);
        check_result("two_pos", 32'h0000_0FFF, 1'b0);
        send(11'h400, 1'b1, 1'b1);
        check("prefix_drains", 64'(out_valid), 64'd0);
        send(11'h000, 1'b0, 1'b1);
        check_result("two_neg", 32'hFFE0_0000, 1'b0);

        // Overflow
        send(11'h7FF, 1'b1, 1'b1);
        send(11'h7FF, 1'b1, 1'b1);
        send(11'h7FF, 1'b0, 1'b1);
        check_result("overflow", 32'hFFFF_FFFF, 1'b1);

        // Backpressure, then no-bubble reload
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h005;
        in_prefix = 1'b0;
        in_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_data", 64'(out_data), 64'hFFFF_FFFF);
            check("bp_hold_ovf", 64'(out_overflow), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_result("no_bubble", 32'h0000_0005, 1'b0);
        tick();

        // Flush discards the pending prefix and blocks the same-cycle chunk
        send(11'h123, 1'b1, 1'b0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 11'h7FF;
        in_prefix = 1'b0;
        in_signed = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_no_valid", 64'(out_valid), 64'd0);
        send(11'h001, 1'b0, 1'b0);
        check_result("after_flush", 32'h0000_0001, 1'b0);

        // Flush leaves a held result alone
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        check_result("flush_held", 32'h0000_0001, 1'b0);
        out_ready = 1'b1;
        tick();

        // Reset mid-accumulation
        send(11'h123, 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_no_result", 64'(out_valid), 64'd0);
        send(11'h002, 1'b0, 1'b0);
        check_result("after_rst", 32'h0000_0002, 1'b0);

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule
